// File: rtl/cpu_pkg.sv
// Shared pipeline-control types and constants for the hazard controller and
// any future forwarding logic that reuses the register comparator.
package cpu_pkg;

  localparam int REG_W = 3;

  // Controller state encoding.
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } state_t;

  // One control word for all pipeline-register enables, flushes and the
  // memory request. This keeps the output decode in one place.
  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic ifidFlush;
    logic idexWrite;
    logic idexFlush;
    logic exmemWrite;
    logic memwbBubble;
    logic dmemReq;
  } ctrl_t;

  // All-zero control word. It is the bubble/NOP value the flush paths load
  // into ID/EX, and the value every output takes while reset is asserted.
  localparam ctrl_t CTRL_BUBBLE = '{pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b0,
                                    idexWrite: 1'b0, idexFlush: 1'b0, exmemWrite: 1'b0,
                                    memwbBubble: 1'b0, dmemReq: 1'b0};

  // Free-running pipeline: every register advances.
  localparam ctrl_t CTRL_RUN = '{pcWrite: 1'b1, ifidWrite: 1'b1, ifidFlush: 1'b0,
                                 idexWrite: 1'b1, idexFlush: 1'b0, exmemWrite: 1'b1,
                                 memwbBubble: 1'b0, dmemReq: 1'b0};

  // Memory access that completes in the cycle it is issued.
  localparam ctrl_t CTRL_RUN_MEM = '{pcWrite: 1'b1, ifidWrite: 1'b1, ifidFlush: 1'b0,
                                     idexWrite: 1'b1, idexFlush: 1'b0, exmemWrite: 1'b1,
                                     memwbBubble: 1'b0, dmemReq: 1'b1};

  // Taken branch: load target into PC, squash the two younger instructions.
  localparam ctrl_t CTRL_REDIRECT = '{pcWrite: 1'b1, ifidWrite: 1'b1, ifidFlush: 1'b1,
                                      idexWrite: 1'b1, idexFlush: 1'b1, exmemWrite: 1'b1,
                                      memwbBubble: 1'b0, dmemReq: 1'b0};

  // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
  localparam ctrl_t CTRL_LOAD_USE = '{pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b0,
                                      idexWrite: 1'b1, idexFlush: 1'b1, exmemWrite: 1'b1,
                                      memwbBubble: 1'b0, dmemReq: 1'b0};

  // Memory still busy: freeze everything up to EX/MEM, bubble into MEM/WB.
  localparam ctrl_t CTRL_FREEZE = '{pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b0,
                                    idexWrite: 1'b0, idexFlush: 1'b0, exmemWrite: 1'b0,
                                    memwbBubble: 1'b1, dmemReq: 1'b1};

  // Memory finishing after a wait: MEM result moves to WB, rest stays frozen.
  localparam ctrl_t CTRL_MEM_DONE = '{pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b0,
                                      idexWrite: 1'b0, idexFlush: 1'b0, exmemWrite: 1'b0,
                                      memwbBubble: 1'b0, dmemReq: 1'b1};

  // Halted: nothing advances, no memory traffic.
  localparam ctrl_t CTRL_HALT = '{pcWrite: 1'b0, ifidWrite: 1'b0, ifidFlush: 1'b0,
                                  idexWrite: 1'b0, idexFlush: 1'b0, exmemWrite: 1'b0,
                                  memwbBubble: 1'b1, dmemReq: 1'b0};

  // True when a source operand is actually read and names the given register.
  function automatic logic regHit(input logic uses,
                                  input logic [REG_W-1:0] src,
                                  input logic [REG_W-1:0] dst);
    return uses & (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master = datapath side (drives hazard inputs), slave = controller.
interface pipe_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  import cpu_pkg::*;

  logic [REG_W-1:0]       idRs;
  logic [REG_W-1:0]       idRt;
  logic                   idUsesRs;
  logic                   idUsesRt;
  logic [REG_W-1:0]       idexWriteReg;
  logic                   idexMemRead;
  logic                   exBranchTaken;
  logic                   exmemMemRead;
  logic                   exmemMemWrite;
  logic                   memwbHalt;
  logic                   dmemDone;

  logic                   pcWrite;
  logic                   ifidWrite;
  logic                   ifidFlush;
  logic                   idexWrite;
  logic                   idexFlush;
  logic                   exmemWrite;
  logic                   memwbBubble;
  logic                   dmemReq;
  logic                   halted;
  logic                   memErr;
  logic [STALL_CNT_W-1:0] stallCount;

  modport master (
    output idRs, idRt, idUsesRs, idUsesRt, idexWriteReg, idexMemRead,
           exBranchTaken, exmemMemRead, exmemMemWrite, memwbHalt, dmemDone,
    input  pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemWrite,
           memwbBubble, dmemReq, halted, memErr, stallCount
  );

  modport slave (
    input  idRs, idRt, idUsesRs, idUsesRt, idexWriteReg, idexMemRead,
           exBranchTaken, exmemMemRead, exmemMemWrite, memwbHalt, dmemDone,
    output pcWrite, ifidWrite, ifidFlush, idexWrite, idexFlush, exmemWrite,
           memwbBubble, dmemReq, halted, memErr, stallCount
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use comparator. Every register, including r0, is
// compared: this ISA has no hard-wired zero register.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic [REG_W-1:0] idexWriteReg,
  input  logic             idexMemRead,
  output logic             loadUse
);

  assign loadUse = idexMemRead &
                   (regHit(idUsesRs, idRs, idexWriteReg) |
                    regHit(idUsesRt, idRt, idexWriteReg));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use stalls,
// branch redirects, multi-cycle data-memory freeze, halt and a saturating
// stall-cycle counter.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int STALL_CNT_W = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave bus
);

  // Last wait cycle index before the timeout fires (waitCnt counts from 0).
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1'b1);

  state_t                 state_r;
  logic [7:0]             waitCnt_r;
  logic                   memErr_r;
  logic [STALL_CNT_W-1:0] stallCount_r;

  logic                   loadUse_s;
  logic                   memOp_s;
  ctrl_t                  ctrl_s;
  ctrl_t                  ctrlOut_s;

  hazard_detect uHazard (
    .idRs         (bus.idRs),
    .idRt         (bus.idRt),
    .idUsesRs     (bus.idUsesRs),
    .idUsesRt     (bus.idUsesRt),
    .idexWriteReg (bus.idexWriteReg),
    .idexMemRead  (bus.idexMemRead),
    .loadUse      (loadUse_s)
  );

  assign memOp_s = bus.exmemMemRead | bus.exmemMemWrite;

  // Control decode: memory freeze beats branch, branch beats load-use. A
  // branch or load-use hidden by a freeze is seen again afterwards because
  // EX and ID are held.
  always_comb begin
    ctrl_s = CTRL_RUN;
    case (state_r)
      RUN: begin
        if (memOp_s) begin
          if (bus.dmemDone) begin
            ctrl_s = CTRL_RUN_MEM;
          end else begin
            ctrl_s = CTRL_FREEZE;
          end
        end else if (bus.exBranchTaken) begin
          ctrl_s = CTRL_REDIRECT;
        end else if (loadUse_s) begin
          ctrl_s = CTRL_LOAD_USE;
        end else begin
          ctrl_s = CTRL_RUN;
        end
      end
      MEM_WAIT: begin
        if (bus.dmemDone) begin
          ctrl_s = CTRL_MEM_DONE;
        end else begin
          ctrl_s = CTRL_FREEZE;
        end
      end
      HALT:    ctrl_s = CTRL_HALT;
      default: ctrl_s = CTRL_HALT;
    endcase
  end

  // Reset gating: while reset is low every output is low, so pipeline
  // registers keep their reset contents regardless of the inputs.
  always_comb begin
    if (rst) begin
      ctrlOut_s = ctrl_s;
    end else begin
      ctrlOut_s = CTRL_BUBBLE;
    end
  end

  assign bus.pcWrite     = ctrlOut_s.pcWrite;
  assign bus.ifidWrite   = ctrlOut_s.ifidWrite;
  assign bus.ifidFlush   = ctrlOut_s.ifidFlush;
  assign bus.idexWrite   = ctrlOut_s.idexWrite;
  assign bus.idexFlush   = ctrlOut_s.idexFlush;
  assign bus.exmemWrite  = ctrlOut_s.exmemWrite;
  assign bus.memwbBubble = ctrlOut_s.memwbBubble;
  assign bus.dmemReq     = ctrlOut_s.dmemReq;
  assign bus.halted      = rst & (state_r == HALT);
  assign bus.memErr      = rst & memErr_r;
  assign bus.stallCount  = rst ? stallCount_r : {STALL_CNT_W{1'b0}};

  // Controller FSM with wait counter and sticky timeout flag; HALT is left
  // only through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= RUN;
      waitCnt_r <= 8'd0;
      memErr_r  <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          waitCnt_r <= 8'd0;
          if (bus.memwbHalt) begin
            state_r <= HALT;
          end else if (memOp_s && !bus.dmemDone) begin
            state_r <= MEM_WAIT;
          end else begin
            state_r <= RUN;
          end
        end
        MEM_WAIT: begin
          if (bus.dmemDone) begin
            state_r   <= RUN;
            waitCnt_r <= 8'd0;
          end else if (waitCnt_r == WAIT_LAST) begin
            state_r   <= HALT;
            memErr_r  <= 1'b1;
            waitCnt_r <= waitCnt_r + 8'd1;
          end else begin
            state_r   <= MEM_WAIT;
            waitCnt_r <= waitCnt_r + 8'd1;
          end
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r <= HALT;
        end
      endcase
    end
  end

  // Saturating count of cycles where the PC was held outside HALT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCount_r <= {STALL_CNT_W{1'b0}};
    end else if (!ctrl_s.pcWrite && (state_r != HALT) && (stallCount_r != STALL_MAX)) begin
      stallCount_r <= stallCount_r + STALL_ONE;
    end else begin
      stallCount_r <= stallCount_r;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl. The stimulus process drives
// one input vector per cycle and queues the hand-computed response; the
// monitor pops and compares on each falling edge.
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;
  localparam int TO = 5;

  // Output word order: pcWrite ifidWrite ifidFlush idexWrite idexFlush
  //                    exmemWrite memwbBubble dmemReq halted memErr
  localparam logic [9:0] O_ZERO   = 10'b0000000000;
  localparam logic [9:0] O_RUN    = 10'b1101010000;
  localparam logic [9:0] O_LU     = 10'b0001110000;
  localparam logic [9:0] O_BR     = 10'b1111110000;
  localparam logic [9:0] O_FRZ    = 10'b0000001100;
  localparam logic [9:0] O_MDONE  = 10'b0000000100;
  localparam logic [9:0] O_RUNMEM = 10'b1101010100;
  localparam logic [9:0] O_HALT   = 10'b0000001010;
  localparam logic [9:0] O_HALTE  = 10'b0000001011;

  typedef struct packed {
    logic [2:0] rs;
    logic [2:0] rt;
    logic       usesRs;
    logic       usesRt;
    logic [2:0] wr;
    logic       exLoad;
    logic       br;
    logic       memRd;
    logic       memWr;
    logic       halt;
    logic       done;
  } stim_t;

  typedef struct {
    string      nm;
    logic [9:0] outs;
    logic [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  exp_t expQ[$];
  exp_t e;
  int   nChecks = 0;
  int   nPass   = 0;

  pipe_hazard_ctrl_if #(.STALL_CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.STALL_CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic [2:0] rs, input logic [2:0] rt,
                               input logic uR, input logic uT, input logic [2:0] wr,
                               input logic ld, input logic br, input logic mr,
                               input logic mw, input logic h, input logic d);
    stim_t s;
    s = {rs, rt, uR, uT, wr, ld, br, mr, mw, h, d};
    return s;
  endfunction

  stim_t S_IDLE, S_LU, S_LU_NOUSE, S_LU_RT, S_LU_R0, S_NOLOAD, S_BRLU;
  stim_t S_LOADBR, S_LOADBR_DONE, S_LOADDONE, S_STORE, S_HALTLU, S_LOAD, S_LOADHALT;

  // Apply one cycle of inputs just after the rising edge and queue the expectation.
  task automatic step(input stim_t s, input logic r, input logic [9:0] o,
                      input logic [3:0] c, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst               = r;
    bus.idRs          = s.rs;
    bus.idRt          = s.rt;
    bus.idUsesRs      = s.usesRs;
    bus.idUsesRt      = s.usesRt;
    bus.idexWriteReg  = s.wr;
    bus.idexMemRead   = s.exLoad;
    bus.exBranchTaken = s.br;
    bus.exmemMemRead  = s.memRd;
    bus.exmemMemWrite = s.memWr;
    bus.memwbHalt     = s.halt;
    bus.dmemDone      = s.done;
    x.nm   = nm;
    x.outs = o;
    x.cnt  = c;
    expQ.push_back(x);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    logic [9:0] act;
    if (expQ.size() > 0) begin
      e   = expQ.pop_front();
      act = {bus.pcWrite, bus.ifidWrite, bus.ifidFlush, bus.idexWrite, bus.idexFlush,
             bus.exmemWrite, bus.memwbBubble, bus.dmemReq, bus.halted, bus.memErr};
      nChecks++;
      if (act !== e.outs) begin
        $display("FAIL %s outputs: got %b want %b", e.nm, act, e.outs);
      end else begin
        nPass++;
      end
      nChecks++;
      if (bus.stallCount !== e.cnt) begin
        $display("FAIL %s stallCount: got %0d want %0d", e.nm, bus.stallCount, e.cnt);
      end else begin
        nPass++;
      end
    end
  end

  initial begin
    S_IDLE        = mk(3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    S_LU          = mk(3'd3, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    S_LU_NOUSE    = mk(3'd3, 3'd2, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    S_LU_RT       = mk(3'd1, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    S_LU_R0       = mk(3'd0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    S_NOLOAD      = mk(3'd3, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    S_BRLU        = mk(3'd3, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    S_LOADBR      = mk(3'd3, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    S_LOADBR_DONE = mk(3'd3, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    S_LOADDONE    = mk(3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    S_STORE       = mk(3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    S_HALTLU      = mk(3'd3, 3'd2, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    S_LOAD        = mk(3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    S_LOADHALT    = mk(3'd1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset held: hazard inputs present but everything must read zero.
    step(S_LU,          1'b0, O_ZERO,   4'd0,  "rstHold0");
    step(S_LU,          1'b0, O_ZERO,   4'd0,  "rstHold1");
    step(S_IDLE,        1'b1, O_RUN,    4'd0,  "runIdle");
    // Load-use variants.
    step(S_LU,          1'b1, O_LU,     4'd0,  "luRs");
    step(S_IDLE,        1'b1, O_RUN,    4'd1,  "luRsAfter");
    step(S_LU_NOUSE,    1'b1, O_RUN,    4'd1,  "luNoUse");
    step(S_LU_RT,       1'b1, O_LU,     4'd1,  "luRt");
    step(S_LU_R0,       1'b1, O_LU,     4'd2,  "luReg0");
    step(S_IDLE,        1'b1, O_RUN,    4'd3,  "idle1");
    step(S_NOLOAD,      1'b1, O_RUN,    4'd3,  "matchNoLoad");
    // Branch outranks load-use; no stall counted.
    step(S_BRLU,        1'b1, O_BR,     4'd3,  "brOverLu");
    step(S_IDLE,        1'b1, O_RUN,    4'd3,  "idle2");
    // Multi-cycle load with pending branch+load-use; done on the 4th cycle.
    step(S_LOADBR,      1'b1, O_FRZ,    4'd3,  "ldFreeze1");
    step(S_LOADBR,      1'b1, O_FRZ,    4'd4,  "ldWait2");
    step(S_LOADBR,      1'b1, O_FRZ,    4'd5,  "ldWait3");
    step(S_LOADBR_DONE, 1'b1, O_MDONE,  4'd6,  "ldDone4");
    step(S_BRLU,        1'b1, O_BR,     4'd7,  "brAfterMem");
    step(S_IDLE,        1'b1, O_RUN,    4'd7,  "idle3");
    // Zero-wait access.
    step(S_LOADDONE,    1'b1, O_RUNMEM, 4'd7,  "ldZeroWait");
    step(S_IDLE,        1'b1, O_RUN,    4'd7,  "idle4");
    // Store that never completes: 5 wait cycles then timeout.
    step(S_STORE,       1'b1, O_FRZ,    4'd7,  "stFreeze");
    step(S_STORE,       1'b1, O_FRZ,    4'd8,  "stWait1");
    step(S_STORE,       1'b1, O_FRZ,    4'd9,  "stWait2");
    step(S_STORE,       1'b1, O_FRZ,    4'd10, "stWait3");
    step(S_STORE,       1'b1, O_FRZ,    4'd11, "stWait4");
    step(S_STORE,       1'b1, O_FRZ,    4'd12, "stWait5");
    step(S_STORE,       1'b1, O_HALTE,  4'd13, "timeoutHalt");
    step(S_IDLE,        1'b1, O_HALTE,  4'd13, "timeoutSticky");
    step(S_LU,          1'b1, O_HALTE,  4'd13, "timeoutHaltLu");
    step(S_LU,          1'b0, O_ZERO,   4'd0,  "rstInErrHalt");
    step(S_IDLE,        1'b1, O_RUN,    4'd0,  "runAfterRst1");
    // memwbHalt entry: RUN outputs this cycle, HALT next.
    step(S_HALTLU,      1'b1, O_LU,     4'd0,  "haltEntry");
    step(S_IDLE,        1'b1, O_HALT,   4'd1,  "halted");
    step(S_LOAD,        1'b1, O_HALT,   4'd1,  "haltNoReq");
    step(S_LOAD,        1'b0, O_ZERO,   4'd0,  "rstInHalt");
    step(S_IDLE,        1'b1, O_RUN,    4'd0,  "runAfterRst2");
    // Saturation at 15.
    for (int k = 0; k < 20; k++) begin
      step(S_LU, 1'b1, O_LU, (k > 15) ? 4'd15 : 4'(k), "satLu");
    end
    step(S_IDLE,        1'b1, O_RUN,    4'd15, "satHold");
    // memwbHalt outranks the MEM_WAIT transition.
    step(S_LOADHALT,    1'b1, O_FRZ,    4'd15, "haltOverMem");
    step(S_IDLE,        1'b1, O_HALT,   4'd15, "haltNotWait");

    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge clk);
    end
    if (expQ.size() > 0) begin
      nChecks++;
      $display("FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
